// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// the NOP word injected on redirect and the default PC width.
package fetch_unit_pkg;

    localparam int PC_WIDTH_DEFAULT = 10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_HOLD  = 2'b01,
        S_DRAIN = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding request
// handshake to instruction memory and feeds the REG1 pipeline wall.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                im_req,
    output logic [PC_WIDTH-1:0] im_addr,
    input  logic                im_ack,
    input  logic [31:0]         im_rdata,
    output logic [31:0]         oIF_instruction,
    output logic [PC_WIDTH-1:0] oIF_current_pc,
    output logic                oIF_valid,
    output logic                do_flush_REG1,
    output logic                im_error
);

    localparam int                  CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    fetch_state_e        state_r,    state_s;
    logic [PC_WIDTH-1:0] pc_r,       pc_s;
    logic                req_r,      req_s;
    logic [PC_WIDTH-1:0] addr_r,     addr_s;
    logic [31:0]         instr_r,    instr_s;
    logic [PC_WIDTH-1:0] cur_pc_r,   cur_pc_s;
    logic                valid_r,    valid_s;
    logic                flush_r,    flush_s;
    logic [31:0]         hold_buf_r, hold_buf_s;
    logic [CNT_W-1:0]    wait_cnt_r;
    logic                error_r;
    logic                ack_s;

    // An ack only counts while a request is actually outstanding.
    assign ack_s = req_r & im_ack;

    // Next-state and next-output logic; redirect overrides everything.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        req_s      = req_r;
        addr_s     = addr_r;
        instr_s    = instr_r;
        cur_pc_s   = cur_pc_r;
        valid_s    = valid_r;
        flush_s    = 1'b0;
        hold_buf_s = hold_buf_r;

        if (redirect) begin
            pc_s    = redirect_pc;
            instr_s = NOP_INSTR;
            valid_s = 1'b0;
            flush_s = 1'b1;
            // An unacked request must still be drained; address stays put.
            if (req_r && !im_ack) begin
                state_s = S_DRAIN;
            end else begin
                state_s = S_FETCH;
                req_s   = 1'b0;
            end
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (!req_r) begin
                        req_s  = 1'b1;
                        addr_s = pc_r;
                    end else if (im_ack) begin
                        req_s = 1'b0;
                        if (stall) begin
                            hold_buf_s = im_rdata;
                            state_s    = S_HOLD;
                        end else begin
                            instr_s  = im_rdata;
                            cur_pc_s = pc_r;
                            valid_s  = 1'b1;
                            pc_s     = pc_r + PC_ONE;
                        end
                    end else begin
                        req_s = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_s  = hold_buf_r;
                        cur_pc_s = pc_r;
                        valid_s  = 1'b1;
                        pc_s     = pc_r + PC_ONE;
                        state_s  = S_FETCH;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (im_ack) begin
                        req_s   = 1'b0;
                        state_s = S_FETCH;
                    end else begin
                        state_s = S_DRAIN;
                    end
                end
                default: begin
                    state_s = S_FETCH;
                    req_s   = 1'b0;
                end
            endcase
        end
    end

    // State, PC, handshake and REG1-facing output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= S_FETCH;
            pc_r       <= PC_RST;
            req_r      <= 1'b0;
            addr_r     <= PC_RST;
            instr_r    <= NOP_INSTR;
            cur_pc_r   <= {PC_WIDTH{1'b0}};
            valid_r    <= 1'b0;
            flush_r    <= 1'b0;
            hold_buf_r <= NOP_INSTR;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            req_r      <= req_s;
            addr_r     <= addr_s;
            instr_r    <= instr_s;
            cur_pc_r   <= cur_pc_s;
            valid_r    <= valid_s;
            flush_r    <= flush_s;
            hold_buf_r <= hold_buf_r == hold_buf_s ? hold_buf_r : hold_buf_s;
        end
    end

    // Ack-wait counter with a sticky timeout flag; the request is never retried.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= CNT_ZERO;
            error_r    <= 1'b0;
        end else if (ack_s) begin
            wait_cnt_r <= CNT_ZERO;
        end else if (req_r) begin
            if (wait_cnt_r != CNT_MAX) begin
                wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end
            if (wait_cnt_r >= CNT_LAST) begin
                error_r <= 1'b1;
            end
        end
    end

    assign im_req          = req_r;
    assign im_addr         = addr_r;
    assign oIF_instruction = instr_r;
    assign oIF_current_pc  = cur_pc_r;
    assign oIF_valid       = valid_r;
    assign do_flush_REG1   = flush_r;
    assign im_error        = error_r;

endmodule
